// File: rtl/imm_packer.sv
`default_nettype none
// ============================================================================
// Module      : imm_packer
// Description : Packs an XLEN-bit immediate into the I/S/B/U/J immediate
//               fields of a caller-supplied instruction template (the inverse
//               of the datapath immediate extender). Requests arrive on a
//               valid/ready input and results leave through a 2-entry FIFO
//               whose head registers drive the outputs directly.
//
// Ports       : clk        - sole clock, rising edge
//               rst        - synchronous reset, active-high
//               in_valid   - request carries imm/imm_type/template
//               in_ready   - packer can accept this cycle
//               imm        - immediate value (full sign-extended form)
//               imm_type   - 0=I 1=S 2=B 3=U 4=J; 5..7 invalid
//               template   - instruction word; imm-field bits overwritten
//               out_valid  - FIFO head valid
//               out_ready  - consumer takes head this cycle
//               out_inst   - packed instruction (FIFO head)
//               out_err    - head word had a range/type error
//               err_count  - saturating count of accepted words in error
//
// Config      : IMM_RANGE_CHECK_EN - when defined, immediates that do not fit
//               their field (or have a nonzero implied-zero LSB) raise
//               out_err and advance err_count. When undefined, out-of-range
//               immediates are silently truncated and only an invalid
//               imm_type is flagged.
//
// Revision    : 1.0 - initial release
// ============================================================================
module imm_packer #(
    parameter int XLEN      = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      imm,
    input  logic [2:0]           imm_type,
    input  logic [XLEN-1:0]      template,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_inst,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [2:0] c_TYPE_I = 3'd0;
    localparam logic [2:0] c_TYPE_S = 3'd1;
    localparam logic [2:0] c_TYPE_B = 3'd2;
    localparam logic [2:0] c_TYPE_U = 3'd3;
    localparam logic [2:0] c_TYPE_J = 3'd4;

    // FIFO state: head registers feed the outputs, tail holds the second entry.
    logic [1:0]           r_count;
    logic [XLEN-1:0]      r_head_inst;
    logic                 r_head_err;
    logic [XLEN-1:0]      r_tail_inst;
    logic                 r_tail_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_pack_inst;
    logic            w_type_err;
    logic            w_err;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // Ready depends only on occupancy, so a full FIFO never accepts even if
    // the consumer pops in the same cycle.
    assign in_ready  = !rst && (r_count < 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Field packing: always uses the truncated bits, even on error.
    // ------------------------------------------------------------------
    always_comb begin
        w_pack_inst = template;
        w_type_err  = 1'b0;
        case (imm_type)
            c_TYPE_I: begin
                w_pack_inst[31:20] = imm[11:0];
            end
            c_TYPE_S: begin
                w_pack_inst[31:25] = imm[11:5];
                w_pack_inst[11:7]  = imm[4:0];
            end
            c_TYPE_B: begin
                w_pack_inst[31]    = imm[12];
                w_pack_inst[30:25] = imm[10:5];
                w_pack_inst[11:8]  = imm[4:1];
                w_pack_inst[7]     = imm[11];
            end
            c_TYPE_U: begin
                w_pack_inst[31:12] = imm[31:12];
            end
            c_TYPE_J: begin
                w_pack_inst[31]    = imm[20];
                w_pack_inst[30:21] = imm[10:1];
                w_pack_inst[20]    = imm[11];
                w_pack_inst[19:12] = imm[19:12];
            end
            default: begin
                w_type_err = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Error classification
    // ------------------------------------------------------------------
`ifdef IMM_RANGE_CHECK_EN
    // An immediate fits an N-bit signed field when every bit from N-1 up to
    // the MSB equals the sign bit, i.e. that slice is all-zeros or all-ones.
    logic w_fit12;
    logic w_fit13;
    logic w_fit21;
    logic w_range_err;

    assign w_fit12 = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign w_fit13 = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign w_fit21 = (imm[31:20] == '0) || (imm[31:20] == '1);

    always_comb begin
        w_range_err = 1'b0;
        case (imm_type)
            c_TYPE_I,
            c_TYPE_S: w_range_err = !w_fit12;
            c_TYPE_B: w_range_err = !w_fit13 || imm[0];
            c_TYPE_U: w_range_err = (imm[11:0] != 12'd0);
            c_TYPE_J: w_range_err = !w_fit21 || imm[0];
            default:  w_range_err = 1'b0;
        endcase
    end

    assign w_err = w_type_err || w_range_err;
`else
    assign w_err = w_type_err;
`endif

    // ------------------------------------------------------------------
    // 2-entry FIFO and saturating error counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= 2'd0;
            r_head_inst <= '0;
            r_head_err  <= 1'b0;
            r_tail_inst <= '0;
            r_tail_err  <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_push && w_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end

            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head_inst <= w_pack_inst;
                        r_head_err  <= w_err;
                        r_count     <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({w_push, w_pop})
                        // Head leaves and the new word takes its place.
                        2'b11: begin
                            r_head_inst <= w_pack_inst;
                            r_head_err  <= w_err;
                        end
                        2'b10: begin
                            r_tail_inst <= w_pack_inst;
                            r_tail_err  <= w_err;
                            r_count     <= 2'd2;
                        end
                        2'b01: begin
                            r_count <= 2'd0;
                        end
                        default: begin
                            r_count <= 2'd1;
                        end
                    endcase
                end
                2'd2: begin
                    // No push possible here: in_ready is low while full.
                    if (w_pop) begin
                        r_head_inst <= r_tail_inst;
                        r_head_err  <= r_tail_err;
                        r_count     <= 2'd1;
                    end
                end
                default: begin
                    r_count <= 2'd0;
                end
            endcase
        end
    end

    assign out_inst  = r_head_inst;
    assign out_err   = r_head_err;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_packer
// Description : Directed self-checking bench for imm_packer. Expected values
//               are hand-computed from the field mapping and range rules;
//               range-error expectations follow IMM_RANGE_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_packer;

`ifdef IMM_RANGE_CHECK_EN
    localparam logic c_RC = 1'b1;
`else
    localparam logic c_RC = 1'b0;
`endif

    localparam int c_NVEC = 14;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] imm;
    logic [2:0]  imm_type;
    logic [31:0] template;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [7:0]  err_count;

    int tests_run;
    int tests_failed;
    int exp_cnt;

    logic [31:0] v_imm  [c_NVEC];
    logic [2:0]  v_type [c_NVEC];
    logic [31:0] v_tmpl [c_NVEC];
    logic [31:0] v_inst [c_NVEC];
    logic        v_err  [c_NVEC];

    imm_packer #(
        .XLEN      (32),
        .ERR_CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .imm_type  (imm_type),
        .template  (template),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_vectors();
        // imm, type, template -> expected inst, expected err
        v_imm[0]  = 32'hFFFF_FFFF; v_type[0]  = 3'd0; v_tmpl[0]  = 32'h0000_0013; v_inst[0]  = 32'hFFF0_0013; v_err[0]  = 1'b0;
        v_imm[1]  = 32'h0000_0010; v_type[1]  = 3'd1; v_tmpl[1]  = 32'h0000_2023; v_inst[1]  = 32'h0000_2823; v_err[1]  = 1'b0;
        v_imm[2]  = 32'hFFFF_FFFC; v_type[2]  = 3'd2; v_tmpl[2]  = 32'h0000_0063; v_inst[2]  = 32'hFE00_0EE3; v_err[2]  = 1'b0;
        v_imm[3]  = 32'h1234_5001; v_type[3]  = 3'd3; v_tmpl[3]  = 32'h0000_0037; v_inst[3]  = 32'h1234_5037; v_err[3]  = c_RC;
        v_imm[4]  = 32'h0000_0800; v_type[4]  = 3'd4; v_tmpl[4]  = 32'h0000_006F; v_inst[4]  = 32'h0010_006F; v_err[4]  = 1'b0;
        v_imm[5]  = 32'hFFFF_FFFE; v_type[5]  = 3'd4; v_tmpl[5]  = 32'h0000_006F; v_inst[5]  = 32'hFFFF_F06F; v_err[5]  = 1'b0;
        v_imm[6]  = 32'hFFFF_FFFF; v_type[6]  = 3'd5; v_tmpl[6]  = 32'hDEAD_BEEF; v_inst[6]  = 32'hDEAD_BEEF; v_err[6]  = 1'b1;
        v_imm[7]  = 32'h0000_0800; v_type[7]  = 3'd0; v_tmpl[7]  = 32'h0000_0013; v_inst[7]  = 32'h8000_0013; v_err[7]  = c_RC;
        v_imm[8]  = 32'h0000_0003; v_type[8]  = 3'd2; v_tmpl[8]  = 32'h0000_0063; v_inst[8]  = 32'h0000_0163; v_err[8]  = c_RC;
        v_imm[9]  = 32'hFFFF_F800; v_type[9]  = 3'd0; v_tmpl[9]  = 32'h0000_0013; v_inst[9]  = 32'h8000_0013; v_err[9]  = 1'b0;
        v_imm[10] = 32'h0010_0000; v_type[10] = 3'd4; v_tmpl[10] = 32'h0000_006F; v_inst[10] = 32'h8000_006F; v_err[10] = c_RC;
        v_imm[11] = 32'hABCD_E000; v_type[11] = 3'd3; v_tmpl[11] = 32'h0000_0017; v_inst[11] = 32'hABCD_E017; v_err[11] = 1'b0;
        v_imm[12] = 32'hFFFF_F7FF; v_type[12] = 3'd1; v_tmpl[12] = 32'h0000_0023; v_inst[12] = 32'h7E00_0FA3; v_err[12] = c_RC;
        v_imm[13] = 32'h0000_0000; v_type[13] = 3'd7; v_tmpl[13] = 32'h1234_5678; v_inst[13] = 32'h1234_5678; v_err[13] = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        imm       = 32'h0;
        imm_type  = 3'd0;
        template  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        tests_run++;
        if ({out_valid, out_err} !== 2'b00 || out_inst !== 32'h0 || err_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b err=%b inst=%h cnt=%0d expected 0/0/0/0",
                     out_valid, out_err, out_inst, err_count);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
        exp_cnt = 0;
    endtask

    // Each vector: push one word, check it appears after one cycle, pop it.
    task automatic test_single_words();
        for (int k = 0; k < c_NVEC; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            imm      = v_imm[k];
            imm_type = v_type[k];
            template = v_tmpl[k];
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL vec%0d_ready: got %b expected 1", k, in_ready);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (v_err[k]) exp_cnt++;
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out_inst !== v_inst[k] || out_err !== v_err[k]) begin
                tests_failed++;
                $display("FAIL vec%0d_word: got valid=%b inst=%h err=%b expected 1/%h/%b",
                         k, out_valid, out_inst, out_err, v_inst[k], v_err[k]);
            end
            tests_run++;
            if (err_count !== 8'(exp_cnt)) begin
                tests_failed++;
                $display("FAIL vec%0d_err_count: got %0d expected %0d", k, err_count, exp_cnt);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL vec%0d_pop: got out_valid=%b expected 0", k, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm_type  = 3'd0;
        template  = 32'h0000_0013;
        imm       = 32'd1;
        @(posedge clk);
        #1 imm = 32'd2;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_inst !== 32'h0010_0013) begin
            tests_failed++;
            $display("FAIL b2b_first: got ready=%b valid=%b inst=%h expected 1/1/00100013",
                     in_ready, out_valid, out_inst);
        end
        @(posedge clk);
        #1 imm = 32'd3;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0 || out_inst !== 32'h0010_0013) begin
            tests_failed++;
            $display("FAIL b2b_full: got ready=%b inst=%h expected 0/00100013", in_ready, out_inst);
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== 32'h0010_0013 || out_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_hold: got ready=%b valid=%b inst=%h err=%b expected 0/1/00100013/0",
                     in_ready, out_valid, out_inst, out_err);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (out_inst !== 32'h0020_0013 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second: got inst=%h ready=%b expected 00200013/1", out_inst, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_inst !== 32'h0030_0013) begin
            tests_failed++;
            $display("FAIL b2b_third: got valid=%b inst=%h expected 1/00300013", out_valid, out_inst);
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_full();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm_type  = 3'd6;
        imm       = 32'h0;
        template  = 32'hCAFE_0000;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        exp_cnt = exp_cnt + 2;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_err !== 1'b1 || err_count !== 8'(exp_cnt)) begin
            tests_failed++;
            $display("FAIL rstfull_filled: got ready=%b valid=%b err=%b cnt=%0d expected 0/1/1/%0d",
                     in_ready, out_valid, out_err, err_count, exp_cnt);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstfull_ready_in_rst: got %b expected 0", in_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b1 ||
            out_inst !== 32'h0 || out_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstfull_after: got valid=%b cnt=%0d ready=%b inst=%h err=%b expected 0/0/1/0/0",
                     out_valid, err_count, in_ready, out_inst, out_err);
        end
    endtask

    // Streams invalid-type words through with push+pop every cycle.
    task automatic test_saturation();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        imm_type  = 3'd5;
        imm       = 32'h0;
        template  = 32'h0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (err_count !== 8'd200) begin
            tests_failed++;
            $display("FAIL sat_midway: got %0d expected 200", err_count);
        end
        repeat (100) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (err_count !== 8'd255) begin
            tests_failed++;
            $display("FAIL sat_limit: got %0d expected 255", err_count);
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || err_count !== 8'd255) begin
            tests_failed++;
            $display("FAIL sat_drain: got valid=%b cnt=%0d expected 0/255", out_valid, err_count);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_cnt      = 0;
        load_vectors();
        test_reset();
        test_single_words();
        test_back_to_back();
        test_reset_full();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
